// File: rtl/mux4_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin channel arbiter.
package mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] i);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_arbiter_rr_pick4.sv
// Purpose: pick the first eligible requester at or after ptr, wrapping 3->0.
// Latency: purely combinational.
// Backpressure: none; mask removes requesters that may not win this pick.
module rr_pick4
    import mux4_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] elig;

    assign elig  = req & mask;
    assign found = |elig;

    // Scan farthest offset first so the closest eligible index to ptr wins last.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[ptr + SEL_W'(k)]) begin
                idx = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Purpose: round-robin owner of a shared 4:1 mux channel with a hold limit; drives sel and one-hot gnt.
// Latency: req sampled at an edge shows up on gnt/sel right after that edge (one register stage).
// Backpressure: a waiting requester forces the owner off after HOLD_MAX cycles; a lone owner holds forever.
module mux4_arbiter
    import mux4_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    arb_state_t         state;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] mask;
    logic               found;
    logic [SEL_W-1:0]   idx;
    logic               others;
    logic               at_limit;
    logic               release_grant;

    // While granted, sel is the owner index, so req[sel] is the owner's request.
    assign others        = |(req & ~gnt);
    assign at_limit      = (cnt == CNT_W'(HOLD_MAX - 1));
    assign release_grant = !req[sel] || (at_limit && others);
    assign mask          = (state == ST_GRANT) ? ~gnt : '1;
    assign busy          = |gnt;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .mask  (mask),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_GRANT;
                        gnt   <= idx2onehot(idx);
                        sel   <= idx;
                        cnt   <= '0;
                        ptr   <= idx + SEL_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        cnt <= '0;
                        if (found) begin
                            gnt <= idx2onehot(idx);
                            sel <= idx;
                            ptr <= idx + SEL_W'(1);
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end else if (!at_limit) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed vector table, round-robin/hold sequences, random traffic vs a reference model.
module tb_mux4_arbiter;

    localparam int HOLD_MAX = 8;
    localparam int NVEC     = 18;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 idle), priority pointer, cycles owned so far.
    int         m_owner;
    int         m_ptr;
    int         m_held;
    logic [1:0] m_sel;

    typedef struct {
        logic       rs;
        logic [3:0] r;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } vec_t;

    vec_t tbl[NVEC];

    mux4_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p, input int excl);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        int   w;
        logic others;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_sel   = 2'd0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_ptr   = (w + 1) % 4;
                m_sel   = w[1:0];
            end
        end else begin
            others = (pick(r, 0, m_owner) >= 0);
            if (!r[m_owner] || (m_held >= HOLD_MAX && others)) begin
                w = pick(r, m_ptr, m_owner);
                if (w >= 0) begin
                    m_owner = w;
                    m_held  = 1;
                    m_ptr   = (w + 1) % 4;
                    m_sel   = w[1:0];
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] one;
        one = 4'b0001;
        return (m_owner < 0) ? 4'b0000 : (one << m_owner);
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic cycle(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        chk("model_gnt", gnt, model_gnt());
        chk("model_busy", busy, m_owner >= 0);
        if (m_owner >= 0) chk("model_sel", sel, m_sel);
        chk("inv_onehot", $onehot0(gnt), 1);
        chk("inv_busy_or", busy, |gnt);
        if (busy) chk("inv_gnt_sel", gnt[sel], 1);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] one;
        logic       rs;
        int         exp_owner;

        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_sel   = 2'd0;
        rst     = 1'b1;
        req     = 4'h0;
        one     = 4'b0001;

        // reset with all requests high
        tbl[0]  = '{1'b1, 4'hF,    4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF,    4'b0000, 2'd0, 1'b0};
        // single requester 2, then drop: sel holds 2
        tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
        // owner 1, then it drops as 3 rises: no bubble
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0};
        // owner 2 reaches cnt=5, reset, then 0110 goes to 1
        tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[10] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[12] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[13] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[14] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[16] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};

        #2;
        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].r, tbl[i].rs);
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].g);
            chk($sformatf("vec%0d_sel", i), sel, tbl[i].s);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].b);
        end

        // all four requesting: 8 cycles each in order 0,1,2,3,0,... with no gaps
        cycle(4'h0, 1'b1);
        for (int c = 0; c < 64; c++) begin
            cycle(4'hF, 1'b0);
            exp_owner = (c / HOLD_MAX) % 4;
            chk("rr_gnt", gnt, one << exp_owner);
            chk("rr_sel", sel, exp_owner);
        end

        // lone requester is never forced off
        cycle(4'h0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            cycle(4'b0001, 1'b0);
            chk("lone_gnt", gnt, 4'b0001);
        end
        cycle(4'h0, 1'b0);
        chk("lone_release", gnt, 4'b0000);

        // random traffic with sticky requests and rare resets
        cycle(4'h0, 1'b1);
        r = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            end
            rs = ($urandom_range(99) == 0);
            cycle(r, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
